// File: rtl/flit_serializer_pipe_if.sv
// Handshake bundle for flit_serializer_pipe: wide input flit side and narrow output flit side.
// The slave modport is the serializer's view; the master modport is the surrounding fabric's view.
interface flit_serializer_pipe_if #(
  parameter int IN_DATA_WIDTH  = 512,
  parameter int OUT_DATA_WIDTH = 64,
  parameter int DEST_BITS      = 4,
  parameter int VC_BITS        = 1
);
  localparam int META_W = 2 + DEST_BITS + VC_BITS;
  localparam int LEN    = (IN_DATA_WIDTH + OUT_DATA_WIDTH - 1) / OUT_DATA_WIDTH;
  localparam int CNT_W  = $clog2(LEN + 1);

  logic [META_W+IN_DATA_WIDTH-1:0]  in_flit;
  logic [CNT_W-1:0]                 in_nbeats;
  logic                             in_flit_valid;
  logic                             in_flit_ready;
  logic [META_W+OUT_DATA_WIDTH-1:0] out_flit;
  logic                             out_flit_valid;
  logic                             out_flit_ready;

  modport master (
    output in_flit, in_nbeats, in_flit_valid, out_flit_ready,
    input  in_flit_ready, out_flit, out_flit_valid
  );

  modport slave (
    input  in_flit, in_nbeats, in_flit_valid, out_flit_ready,
    output in_flit_ready, out_flit, out_flit_valid
  );
endinterface

// File: rtl/flit_serializer_pipe.sv
// Serializes one wide NoC flit into up to LEN narrow flits, reloading on the last beat with no bubble.
// Optional macro FLITSER_STATS_EN adds stat_in_flits / stat_out_beats fire counters.
module flit_serializer_pipe #(
  parameter int IN_DATA_WIDTH  = 512,
  parameter int OUT_DATA_WIDTH = 64,
  parameter int DEST_BITS      = 4,
  parameter int VC_BITS        = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  flit_serializer_pipe_if.slave bus
`ifdef FLITSER_STATS_EN
  ,
  output logic [31:0]           stat_in_flits,
  output logic [31:0]           stat_out_beats
`endif
);

  localparam int META_W = 2 + DEST_BITS + VC_BITS;
  localparam int LEN    = (IN_DATA_WIDTH + OUT_DATA_WIDTH - 1) / OUT_DATA_WIDTH;
  localparam int CNT_W  = $clog2(LEN + 1);
  localparam int IDX_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PAD_W  = LEN * OUT_DATA_WIDTH;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SEND
  } state_e;

  typedef logic [LEN-1:0][OUT_DATA_WIDTH-1:0] lanes_t;

  state_e                  state_q,  state_d;
  logic   [CNT_W-1:0]      cnt_q,    cnt_d;
  logic   [CNT_W-1:0]      nbeats_q, nbeats_d;
  logic   [META_W-1:0]     meta_q,   meta_d;
  lanes_t                  data_q,   data_d;

  logic                    in_ready;
  logic                    out_valid;
  logic [META_W+OUT_DATA_WIDTH-1:0] out_flit;
  logic                    in_fire;
  logic                    out_fire;
  logic                    last_beat;
  logic [CNT_W-1:0]        nbeats_clamped;
  logic [META_W-1:0]       in_meta;
  logic [PAD_W-1:0]        in_data_padded;
  logic [OUT_DATA_WIDTH-1:0] beat_data;

  // Payload is zero-extended so lanes above IN_DATA_WIDTH emit zeros.
  assign in_meta        = bus.in_flit[META_W+IN_DATA_WIDTH-1 -: META_W];
  assign in_data_padded = PAD_W'(bus.in_flit[IN_DATA_WIDTH-1:0]);

  assign nbeats_clamped = (bus.in_nbeats == '0 || bus.in_nbeats > LEN_C) ? LEN_C : bus.in_nbeats;

  assign last_beat = (cnt_q == nbeats_q - CNT_W'(1));
  assign beat_data = data_q[cnt_q[IDX_W-1:0]];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_flit  = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        // A new flit may enter only as the final beat actually leaves.
        in_ready  = last_beat && bus.out_flit_ready;
        out_flit  = {meta_q[META_W-1],
                     meta_q[META_W-2] & last_beat,
                     meta_q[META_W-3:0],
                     beat_data};
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign in_fire  = bus.in_flit_valid && in_ready;
  assign out_fire = out_valid && bus.out_flit_ready;

  assign bus.in_flit_ready  = in_ready;
  assign bus.out_flit_valid = out_valid;
  assign bus.out_flit       = out_flit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbeats_d = nbeats_q;
    meta_d   = meta_q;
    data_d   = data_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
      end
      ST_SEND: begin
        if (out_fire) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Loading overrides the return to idle, giving back-to-back flits with no gap.
    if (in_fire) begin
      state_d  = ST_SEND;
      cnt_d    = '0;
      nbeats_d = nbeats_clamped;
      meta_d   = in_meta;
      data_d   = lanes_t'(in_data_padded);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: the payload registers are reset too, so out_flit is fully defined from the first cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      nbeats_q <= '0;
      meta_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbeats_q <= nbeats_d;
      meta_q   <= meta_d;
      data_q   <= data_d;
    end
  end

`ifdef FLITSER_STATS_EN
  logic [31:0] stat_in_q;
  logic [31:0] stat_out_q;

  // Free-running counters; wrap naturally modulo 2^32.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      if (in_fire) begin
        stat_in_q <= stat_in_q + 32'd1;
      end
      if (out_fire) begin
        stat_out_q <= stat_out_q + 32'd1;
      end
    end
  end

  assign stat_in_flits  = stat_in_q;
  assign stat_out_beats = stat_out_q;
`endif

endmodule
